check_nodes_serial: RTL and testbench
=====================================

Name: check_nodes_serial

Overview:
- Even-layer (check-node) stage of the neural offset min-sum decoder. It sits directly downstream of the variable-node layer and directly upstream of the next variable-node iteration.
- Consumes the E variable-to-check edge messages as a stream in Tanner-edge order. Computes per-check min1/min2/argmin/sign parity with a learnable offset beta.
- Emits the E check-to-variable messages in the same edge order. The next variable-node layer uses these as prev_proc_elem.

Parameters:
- N_V, 44, number of variable nodes (index width only)
- N_C, 12, number of check nodes
- E, 147, number of Tanner-graph edges per frame

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  pulse; begins a frame, latches beta
- beta  input  7  unsigned offset subtracted from magnitudes (learned per layer)
- in_valid  input  1  edge message valid
- in_ready  output  1  block accepts edge message
- in_msg  input  8  signed variable-to-check message
- in_chk  input  8  check-node index of this edge (tanner_g[e][1])
- out_valid  output  1  check-to-variable message valid
- out_ready  input  1  downstream accepts
- out_msg  output  8  signed check-to-variable message
- out_last  output  1  high with edge E-1 output
- busy  output  1  frame in progress (state != IDLE)
- err  output  1  sticky: an in_chk >= N_C was received; cleared on start

Behaviour:
- Reset (async, rst low) forces the following, regardless of state:
  - state=IDLE; outputs in_ready=0, out_valid=0, out_msg=0, out_last=0, busy=0, err=0
  - counters 0; per-check arrays cleared (min1=min2=127, idx=0, par=0)
  - Reset mid-frame discards the frame.
- FSM states:
  - IDLE: waits for start; start=1 -> CLEAR. Latches beta, clears err.
  - CLEAR: one cycle. Sets all N_C entries to min1=127, min2=127, idx=0, par=0 -> COLLECT. start is ignored outside IDLE.
  - COLLECT: in_ready=1. Each in_valid&in_ready cycle does the following:
    - store msg and chk in edge buffer [cnt]; cnt++
    - m = |msg|, saturated (-128 -> 127); s = msg[7]
    - update entry c=in_chk:
      - if m<min1: min2=min1, min1=m, idx=cnt
      - else if m<min2: min2=m
      - Ties (m==min1) go to min2; idx keeps the first occurrence.
    - par ^= s
    - After edge E-1 is accepted, cnt=0 -> EMIT. in_ready drops the next cycle.
  - EMIT: in_ready=0. Edge buffer [cnt] is read combinationally into an output register. out_valid holds until out_ready.
    - Output for edge e on check c:
      - mag = (e==idx[c]) ? min2[c] : min1[c]
      - mag' = max(mag - beta, 0)
      - sign = par[c] ^ msg_e[7]
      - out_msg = sign ? -mag' : mag'
    - out_last=1 on e=E-1. The handshake on the last edge -> IDLE, out_valid=0.
- Latency: first out_valid 1 cycle after the last input handshake. Throughput is 1 message/cycle when out_ready=1. A frame takes 1+E+E cycles minimum.
- Zero message counts as positive (sign bit 0).
- Degree-1 check: min2=127, so output magnitude = max(127-beta,0) with sign +. This is the defined behaviour.
- Invalid in_chk (>= N_C): no array update; err=1; the edge's output is 0.
- Backpressure: out_msg/out_last must be stable while out_valid&!out_ready. in_valid in non-COLLECT states is ignored.
- Widths:
  - edge counter clog2(E)
  - magnitude 7 bits; beta subtraction in 8 bits, clamped at 0
  - outputs range -127..127, never -128

Decomposition:
- Package nms_pkg:
  - MSG_W=8, MAG_MAX=127
  - typedef msg_t (signed 8), mag_t (7 bits)
  - typedef chk_state_t struct {min1, min2, idx, par}
  - function sat_abs
- Shared with variable_nodes and the future decoder top.
- Sub-module: check_minsum_update. Combinational; takes chk_state_t and a new magnitude/sign/idx and returns the updated chk_state_t. Reusable for a parallel variant.

Test Plan:
- Bench uses small params N_C=2, E=4; edges chk={0,0,0,1}, msgs {5,-3,9,-8}, beta=0.
  - Expected outputs {-3,5,-3,127}; err=0; out_last on 4th.
- Same frame, beta=4 -> outputs {0,1,0,123}.
- Saturation/ties on chk={0,0,0,1}: msgs {-128,-128,2,1}, beta=0 -> outputs {-2,-2,127,127}.
  - The two -128 inputs become 127 (tie).
- Backpressure: hold out_ready=0 for 3 cycles at edge 1 -> out_msg stable, no edge skipped or duplicated. Throughput returns to 1/cycle after release.
- Invalid index: edge 2 chk=5 -> err=1, edge 2 output 0, other edges computed as if absent. Next start clears err.
- Async reset asserted mid-COLLECT (after 2 edges):
  - all outputs 0 immediately, state IDLE
  - a subsequent full frame produces correct results with no stale min values

Source files
------------

// File: rtl/nms_pkg.sv
// Shared types and helpers for the neural offset min-sum decoder layers
// (variable_nodes, check_nodes_serial and the decoder top).
package nms_pkg;

    localparam int MSG_W = 8;
    localparam int MAG_W = 7;
    localparam int IDX_W = 8;

    localparam logic [MAG_W-1:0] MAG_MAX = 7'd127;

    typedef logic signed [MSG_W-1:0] msg_t;
    typedef logic [MAG_W-1:0]        mag_t;
    typedef logic [IDX_W-1:0]        idx_t;

    typedef struct packed {
        mag_t min1;
        mag_t min2;
        idx_t idx;
        logic par;
    } chk_state_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_EMIT    = 2'd3
    } cn_state_t;

    localparam chk_state_t CHK_INIT = '{min1: MAG_MAX, min2: MAG_MAX, idx: 8'd0, par: 1'b0};

    // Magnitude of a signed message; -128 saturates to 127 so it fits in 7 bits.
    function automatic mag_t sat_abs(input msg_t m);
        mag_t r;
        if (m[MSG_W-1] && (m[MSG_W-2:0] == 7'd0)) begin
            r = MAG_MAX;
        end else if (m[MSG_W-1]) begin
            r = mag_t'(-m);
        end else begin
            r = m[MAG_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/check_minsum_update.sv
// Combinational per-check min1/min2/argmin/parity update for one incoming edge.
module check_minsum_update
    import nms_pkg::*;
(
    input  chk_state_t cur,
    input  mag_t       mag,
    input  logic       sign,
    input  idx_t       idx,
    output chk_state_t nxt
);

    // Ties with min1 fall through to min2 so idx keeps the first occurrence.
    always_comb begin
        nxt = cur;
        if (mag < cur.min1) begin
            nxt.min2 = cur.min1;
            nxt.min1 = mag;
            nxt.idx  = idx;
        end else if (mag < cur.min2) begin
            nxt.min2 = mag;
        end else begin
            nxt.min2 = cur.min2;
        end
        nxt.par = cur.par ^ sign;
    end

endmodule

// File: rtl/check_nodes_serial.sv
// Serial check-node layer: collects E edge messages per frame, then emits the
// offset min-sum check-to-variable messages in the same edge order.
module check_nodes_serial
    import nms_pkg::*;
#(
    parameter int N_V = 44,
    parameter int N_C = 12,
    parameter int E   = 147
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] beta,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_msg,
    input  logic [7:0] in_chk,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_msg,
    output logic       out_last,
    output logic       busy,
    output logic       err
);

    localparam int CNT_W = (E > 1) ? $clog2(E) : 1;
    localparam int CHK_W = (N_C > 1) ? $clog2(N_C) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(E - 1);

    if ((N_V < 1) || (N_C < 1) || (E < 2) || (E > (2 ** IDX_W))) begin : g_bad_params
        $error("check_nodes_serial: unsupported N_V/N_C/E combination");
    end

    cn_state_t        state_r;
    cn_state_t        state_nxt_s;
    logic [6:0]       beta_r;
    logic [CNT_W-1:0] cnt_r;
    chk_state_t       chk_r [N_C];
    msg_t             msg_buf_r [E];
    logic [7:0]       chk_buf_r [E];

    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic             busy_r;
    logic             err_r;
    msg_t             out_msg_r;

    logic             accept_s;
    logic             in_ok_s;
    logic [CHK_W-1:0] in_sel_s;
    mag_t             in_mag_s;
    chk_state_t       upd_s;

    logic             load_s;
    logic             last_hs_s;
    msg_t             em_msg_s;
    logic [7:0]       em_chk_s;
    logic             em_ok_s;
    logic [CHK_W-1:0] em_sel_s;
    chk_state_t       em_st_s;
    mag_t             em_mag_s;
    mag_t             em_off_s;
    logic             em_sign_s;
    msg_t             em_out_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_msg   = out_msg_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign err       = err_r;

    // Input-side decode: handshake, index range check and magnitude.
    always_comb begin
        accept_s = in_valid && in_ready_r && (state_r == ST_COLLECT);
        in_ok_s  = (in_chk < 8'(N_C));
        if (in_ok_s) begin
            in_sel_s = in_chk[CHK_W-1:0];
        end else begin
            in_sel_s = '0;
        end
        in_mag_s = sat_abs(msg_t'(in_msg));
    end

    check_minsum_update u_update (
        .cur  (chk_r[in_sel_s]),
        .mag  (in_mag_s),
        .sign (in_msg[7]),
        .idx  (IDX_W'(cnt_r)),
        .nxt  (upd_s)
    );

    // Output-side compute: the edge at cnt_r against its final check state.
    always_comb begin
        load_s    = (state_r == ST_EMIT) && (!out_valid_r || (out_ready && !out_last_r));
        last_hs_s = (state_r == ST_EMIT) && out_valid_r && out_ready && out_last_r;
        em_msg_s  = msg_buf_r[cnt_r];
        em_chk_s  = chk_buf_r[cnt_r];
        em_ok_s   = (em_chk_s < 8'(N_C));
        if (em_ok_s) begin
            em_sel_s = em_chk_s[CHK_W-1:0];
        end else begin
            em_sel_s = '0;
        end
        em_st_s = chk_r[em_sel_s];
        if (IDX_W'(cnt_r) == em_st_s.idx) begin
            em_mag_s = em_st_s.min2;
        end else begin
            em_mag_s = em_st_s.min1;
        end
        if (em_mag_s > beta_r) begin
            em_off_s = em_mag_s - beta_r;
        end else begin
            em_off_s = 7'd0;
        end
        em_sign_s = em_st_s.par ^ em_msg_s[7];
        if (!em_ok_s) begin
            em_out_s = 8'sd0;
        end else if (em_sign_s) begin
            em_out_s = -msg_t'({1'b0, em_off_s});
        end else begin
            em_out_s = msg_t'({1'b0, em_off_s});
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (accept_s && (cnt_r == CNT_LAST)) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                if (last_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Control, per-check arrays and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_msg_r   <= 8'sd0;
            err_r       <= 1'b0;
            beta_r      <= 7'd0;
            cnt_r       <= '0;
            for (int i = 0; i < N_C; i++) begin
                chk_r[i] <= CHK_INIT;
            end
        end else begin
            in_ready_r <= (state_nxt_s == ST_COLLECT);
            busy_r     <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        beta_r <= beta;
                        err_r  <= 1'b0;
                        cnt_r  <= '0;
                    end
                end
                ST_CLEAR: begin
                    for (int i = 0; i < N_C; i++) begin
                        chk_r[i] <= CHK_INIT;
                    end
                end
                ST_COLLECT: begin
                    if (accept_s) begin
                        if (cnt_r == CNT_LAST) begin
                            cnt_r <= '0;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                        if (in_ok_s) begin
                            chk_r[in_sel_s] <= upd_s;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (load_s) begin
                        out_valid_r <= 1'b1;
                        out_msg_r   <= em_out_s;
                        out_last_r  <= (cnt_r == CNT_LAST);
                        if (cnt_r == CNT_LAST) begin
                            cnt_r <= '0;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end else if (last_hs_s) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        out_msg_r   <= 8'sd0;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // Edge buffer: written once per accepted edge, read back during emission.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            msg_buf_r[cnt_r] <= msg_t'(in_msg);
            chk_buf_r[cnt_r] <= in_chk;
        end
    end

endmodule

// File: tb/tb_check_nodes_serial.sv
// Directed bench for check_nodes_serial with a 2-check, 4-edge graph.
module tb_check_nodes_serial;

    localparam int N_C = 2;
    localparam int E   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [6:0]        beta;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_msg;
    logic [7:0]        in_chk;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_msg;
    logic              out_last;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] msgs [4];
    logic [7:0]        chks [4];
    logic signed [7:0] expv [4];

    always #5 clk = ~clk;

    check_nodes_serial #(.N_V(44), .N_C(N_C), .E(E)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .beta      (beta),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .in_chk    (in_chk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete frame; hold >= 0 stalls out_ready for 3 cycles at that edge.
    task automatic run_frame(input string name, input logic [6:0] b, input int hold, input logic exp_err);
        int t;
        start = 1'b1;
        beta  = b;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_start"}, busy, 1);
        t = 0;
        while (in_ready !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < E; i++) begin
            check($sformatf("%s_in_ready%0d", name, i), in_ready, 1);
            in_valid = 1'b1;
            in_msg   = msgs[i];
            in_chk   = chks[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({name, "_in_ready_drop"}, in_ready, 0);
        t = 0;
        while (out_valid !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        check({name, "_first_latency"}, t, 1);
        for (int i = 0; i < E; i++) begin
            if (i == hold) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("%s_hold_valid%0d", name, k), out_valid, 1);
                    check($sformatf("%s_hold_msg%0d", name, k), out_msg, expv[i]);
                    check($sformatf("%s_hold_last%0d", name, k), out_last, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check($sformatf("%s_valid%0d", name, i), out_valid, 1);
            check($sformatf("%s_msg%0d", name, i), out_msg, expv[i]);
            check($sformatf("%s_last%0d", name, i), out_last, (i == E - 1) ? 1 : 0);
            @(negedge clk);
        end
        check({name, "_valid_end"}, out_valid, 0);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_err"}, err, exp_err);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        beta      = 7'd0;
        in_valid  = 1'b0;
        in_msg    = 8'd0;
        in_chk    = 8'd0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        msgs = '{8'sd5, -8'sd3, 8'sd9, -8'sd8};
        chks = '{8'd0, 8'd0, 8'd0, 8'd1};
        expv = '{-8'sd3, 8'sd5, -8'sd3, 8'sd127};
        run_frame("f1_b0", 7'd0, -1, 1'b0);

        expv = '{8'sd0, 8'sd1, 8'sd0, 8'sd123};
        run_frame("f1_b4_bp", 7'd4, 1, 1'b0);

        msgs = '{-8'sd128, -8'sd128, 8'sd2, 8'sd1};
        expv = '{-8'sd2, -8'sd2, 8'sd127, 8'sd127};
        run_frame("sat_tie", 7'd0, -1, 1'b0);

        msgs = '{8'sd5, -8'sd3, 8'sd9, -8'sd8};
        chks = '{8'd0, 8'd0, 8'd5, 8'd1};
        expv = '{-8'sd3, 8'sd5, 8'sd0, 8'sd127};
        run_frame("bad_chk", 7'd0, -1, 1'b1);

        chks = '{8'd0, 8'd0, 8'd0, 8'd1};
        expv = '{-8'sd3, 8'sd5, -8'sd3, 8'sd127};
        run_frame("err_clear", 7'd0, -1, 1'b0);

        // Partial frame with small magnitudes, then reset mid-collection.
        start = 1'b1;
        beta  = 7'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_msg   = 8'd1;
            in_chk   = 8'd0;
            @(negedge clk);
        end
        check("mid_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_in_ready", in_ready, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_out_msg", out_msg, 0);
        check("mid_out_last", out_last, 0);
        check("mid_busy", busy, 0);
        check("mid_err", err, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame("after_rst", 7'd0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
